// File: rtl/clock_pkg.sv
// Shared constants, types and helpers for the clock time-setting controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package clock_pkg;

  // Field widths
  localparam int HR_W = 5;
  localparam int MS_W = 6;

  // Field maxima, held at the wider width so one set of helpers serves all fields
  localparam logic [MS_W-1:0] HR_MAX  = 6'd23;
  localparam logic [MS_W-1:0] MIN_MAX = 6'd59;
  localparam logic [MS_W-1:0] SEC_MAX = 6'd59;

  // blink_mask bit positions
  localparam int BLINK_HR_BIT  = 2;
  localparam int BLINK_MIN_BIT = 1;
  localparam int BLINK_SEC_BIT = 0;

  // Edit FSM state; the encoding is also the external mode output
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

  // One hh:mm:ss value
  typedef struct packed {
    logic [HR_W-1:0] hr;
    logic [MS_W-1:0] mins;
    logic [MS_W-1:0] secs;
  } time_t;

  // Out-of-range values saturate at the field maximum
  function automatic logic [MS_W-1:0] clamp_field(input logic [MS_W-1:0] v,
                                                  input logic [MS_W-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // Increment with wrap from max back to zero
  function automatic logic [MS_W-1:0] wrap_inc(input logic [MS_W-1:0] v,
                                               input logic [MS_W-1:0] mx);
    return (v >= mx) ? '0 : v + MS_W'(1);
  endfunction

  // Decrement with wrap from zero up to max
  function automatic logic [MS_W-1:0] wrap_dec(input logic [MS_W-1:0] v,
                                               input logic [MS_W-1:0] mx);
    return ((v == '0) || (v > mx)) ? mx : v - MS_W'(1);
  endfunction

  // Active field shows the blink phase; every other field stays lit
  function automatic logic [2:0] blink_for(input state_e st, input logic phase);
    logic [2:0] m;
    m = 3'b000;
    case (st)
      SET_HR:  m[BLINK_HR_BIT]  = phase;
      SET_MIN: m[BLINK_MIN_BIT] = phase;
      SET_SEC: m[BLINK_SEC_BIT] = phase;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable samples, then a 1-cycle btn_evt.
// Backpressure: none; btn_evt is a fire-and-forget pulse, one per debounced press.
// Ports: clk, reset (async active-low), btn_raw (async input), btn_evt (press pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_evt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q,  sync_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             level_q, level_d;
  logic             evt_q,   evt_d;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level; a bounce back to the old level resets it, so any change
  // restarts the stability window.
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    cnt_d   = cnt_q;
    level_d = level_q;
    evt_d   = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync_q[1];
      evt_d   = sync_q[1];   // pulse only on the 0->1 transition
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      evt_q   <= evt_d;
    end
  end

  assign btn_evt = evt_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: debounced buttons drive an edit FSM that freezes,
// edits and reloads the hr/min/sec counter, plus a per-field blink mask.
// Latency: outputs update on the clk edge after a press event; load is a 1-cycle strobe.
// Backpressure: none; the counter must accept load whenever it is asserted.
// Ports: clk, reset (async active-low), tick_1hz (clock enable), btn_mode/inc/dec (raw),
//        cur_hr/min/sec (counter value) in; run_en, load, load_hr/min/sec, blink_mask, mode out.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int IDLE_TIMEOUT    = 30
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick_1hz,
  input  logic            btn_mode,
  input  logic            btn_inc,
  input  logic            btn_dec,
  input  logic [HR_W-1:0] cur_hr,
  input  logic [MS_W-1:0] cur_min,
  input  logic [MS_W-1:0] cur_sec,
  output logic            run_en,
  output logic            load,
  output logic [HR_W-1:0] load_hr,
  output logic [MS_W-1:0] load_min,
  output logic [MS_W-1:0] load_sec,
  output logic [2:0]      blink_mask,
  output logic [1:0]      mode
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT);

  logic mode_evt, inc_evt, dec_evt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_mode),
    .btn_evt (mode_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_inc),
    .btn_evt (inc_evt)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_dec),
    .btn_evt (dec_evt)
  );

  state_e            state_q,    state_d;
  time_t             edit_q,     edit_d;
  time_t             load_val_q, load_val_d;
  logic              load_q,     load_d;
  logic              run_en_q,   run_en_d;
  logic              phase_q,    phase_d;
  logic [IDLE_W-1:0] idle_q,     idle_d;
  logic [2:0]        blink_q,    blink_d;

  logic              any_evt;
  logic              inc_only;
  logic              dec_only;
  logic [IDLE_W-1:0] idle_inc;

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    load_val_d = load_val_q;
    load_d     = 1'b0;
    run_en_d   = run_en_q;
    phase_d    = phase_q;
    idle_d     = idle_q;

    any_evt  = mode_evt | inc_evt | dec_evt;
    // Opposing inc/dec in one cycle cancel each other out
    inc_only = inc_evt & ~dec_evt;
    dec_only = dec_evt & ~inc_evt;
    idle_inc = idle_q + IDLE_W'(1);

    if (state_q == RUN) begin
      run_en_d = 1'b1;
      phase_d  = 1'b0;
      idle_d   = '0;
      if (mode_evt) begin
        edit_d.hr   = HR_W'(clamp_field(MS_W'(cur_hr), HR_MAX));
        edit_d.mins = clamp_field(cur_min, MIN_MAX);
        edit_d.secs = clamp_field(cur_sec, SEC_MAX);
        state_d     = SET_HR;
        run_en_d    = 1'b0;
        phase_d     = 1'b1;   // field goes dark right away on entry
      end
    end else begin
      if (tick_1hz) begin
        phase_d = ~phase_q;
      end

      if (mode_evt) begin
        // mode outranks any inc/dec arriving in the same cycle
        idle_d  = '0;
        phase_d = 1'b1;
        case (state_q)
          SET_HR:  state_d = SET_MIN;
          SET_MIN: state_d = SET_SEC;
          default: begin
            state_d    = RUN;
            run_en_d   = 1'b1;
            load_d     = 1'b1;
            load_val_d = edit_q;
            phase_d    = 1'b0;
          end
        endcase
      end else if (any_evt) begin
        // A button event beats a coincident tick for the idle counter
        idle_d = '0;
        if (inc_only) begin
          case (state_q)
            SET_HR:  edit_d.hr   = HR_W'(wrap_inc(MS_W'(edit_q.hr), HR_MAX));
            SET_MIN: edit_d.mins = wrap_inc(edit_q.mins, MIN_MAX);
            default: edit_d.secs = wrap_inc(edit_q.secs, SEC_MAX);
          endcase
        end else if (dec_only) begin
          case (state_q)
            SET_HR:  edit_d.hr   = HR_W'(wrap_dec(MS_W'(edit_q.hr), HR_MAX));
            SET_MIN: edit_d.mins = wrap_dec(edit_q.mins, MIN_MAX);
            default: edit_d.secs = wrap_dec(edit_q.secs, SEC_MAX);
          endcase
        end
      end else if (tick_1hz) begin
        if (idle_inc == IDLE_LAST) begin
          // Abandon the edit; the counter resumes from where it was frozen
          state_d  = RUN;
          run_en_d = 1'b1;
          phase_d  = 1'b0;
          idle_d   = '0;
        end else begin
          idle_d = idle_inc;
        end
      end
    end

    blink_d = blink_for(state_d, phase_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      edit_q     <= '0;
      load_val_q <= '0;
      load_q     <= 1'b0;
      run_en_q   <= 1'b1;
      phase_q    <= 1'b0;
      idle_q     <= '0;
      blink_q    <= 3'b000;
    end else begin
      state_q    <= state_d;
      edit_q     <= edit_d;
      load_val_q <= load_val_d;
      load_q     <= load_d;
      run_en_q   <= run_en_d;
      phase_q    <= phase_d;
      idle_q     <= idle_d;
      blink_q    <= blink_d;
    end
  end

  assign run_en     = run_en_q;
  assign load       = load_q;
  assign load_hr    = load_val_q.hr;
  assign load_min   = load_val_q.mins;
  assign load_sec   = load_val_q.secs;
  assign blink_mask = blink_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce and idle timeout.
// Latency: a press resolves within 10 cycles of the raw button rising.
// Backpressure: n/a.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [4:0] cur_hr = '0;
  logic [5:0] cur_min = '0;
  logic [5:0] cur_sec = '0;
  logic       run_en;
  logic       load;
  logic [4:0] load_hr;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic [2:0] blink_mask;
  logic [1:0] mode;

  int passed = 0;
  int total  = 0;

  // Observations gathered on every sampled negedge
  int         load_seen = 0;
  logic [4:0] cap_hr;
  logic [5:0] cap_min;
  logic [5:0] cap_sec;
  logic       cap_run_en;
  bit         track_run = 1'b0;
  int         run_hi_cnt = 0;

  always #5 clk = ~clk;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .IDLE_TIMEOUT    (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .btn_dec    (btn_dec),
    .cur_hr     (cur_hr),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .run_en     (run_en),
    .load       (load),
    .load_hr    (load_hr),
    .load_min   (load_min),
    .load_sec   (load_sec),
    .blink_mask (blink_mask),
    .mode       (mode)
  );

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (load === 1'b1) begin
        load_seen++;
        cap_hr     = load_hr;
        cap_min    = load_min;
        cap_sec    = load_sec;
        cap_run_en = run_en;
      end
      if (track_run && run_en !== 1'b0) run_hi_cnt++;
    end
  endtask

  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    wait_cycles(10);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    wait_cycles(10);
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    wait_cycles(1);
    tick_1hz = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    total++; if (mode !== 2'd0) $display("FAIL reset_mode got %0d want 0", mode); else passed++;
    total++; if (run_en !== 1'b1) $display("FAIL reset_run_en got %b want 1", run_en); else passed++;
    total++; if (load !== 1'b0) $display("FAIL reset_load got %b want 0", load); else passed++;
    total++; if ({load_hr, load_min, load_sec} !== 17'd0)
      $display("FAIL reset_load_val got %0d:%0d:%0d want 0:0:0", load_hr, load_min, load_sec); else passed++;
    total++; if (blink_mask !== 3'b000) $display("FAIL reset_blink got %b want 000", blink_mask); else passed++;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    wait_cycles(3);
    total++; if (mode !== 2'd0 || run_en !== 1'b1)
      $display("FAIL post_reset got mode=%0d run_en=%b want 0/1", mode, run_en); else passed++;
  endtask

  task automatic test_debounce();
    int l0;
    cur_hr = 5'd5; cur_min = 6'd0; cur_sec = 6'd0;
    l0 = load_seen;
    press(1, 0, 0);
    total++; if (mode !== 2'd1 || run_en !== 1'b0)
      $display("FAIL enter_set_hr got mode=%0d run_en=%b want 1/0", mode, run_en); else passed++;
    total++; if (blink_mask !== 3'b100) $display("FAIL blink_enter_hr got %b want 100", blink_mask); else passed++;
    // Bouncing input: no run of 4 equal samples
    for (int k = 0; k < 10; k++) begin
      btn_inc = ~btn_inc;
      wait_cycles(2);
    end
    btn_inc = 1'b1;
    wait_cycles(10);
    btn_inc = 1'b0;
    wait_cycles(10);
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    total++; if (load_seen !== l0 + 1) $display("FAIL debounce_load_count got %0d want %0d", load_seen - l0, 1); else passed++;
    total++; if ({cap_hr, cap_min, cap_sec} !== {5'd6, 6'd0, 6'd0})
      $display("FAIL debounce_single_event got %0d:%0d:%0d want 6:0:0", cap_hr, cap_min, cap_sec); else passed++;
  endtask

  task automatic test_full_set();
    int l0;
    cur_hr = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    l0 = load_seen;
    press(1, 0, 0);
    track_run = 1'b1; run_hi_cnt = 0;
    for (int k = 0; k < 14; k++) press(0, 1, 0);
    press(1, 0, 0);
    total++; if (mode !== 2'd2) $display("FAIL full_set_min_state got %0d want 2", mode); else passed++;
    for (int k = 0; k < 21; k++) press(0, 0, 1);
    press(1, 0, 0);
    total++; if (mode !== 2'd3 || blink_mask !== 3'b001)
      $display("FAIL full_set_sec_state got mode=%0d mask=%b want 3/001", mode, blink_mask); else passed++;
    press(0, 1, 0);
    track_run = 1'b0;
    total++; if (run_hi_cnt !== 0) $display("FAIL run_en_editing got %0d high samples want 0", run_hi_cnt); else passed++;
    total++; if (load_seen !== l0) $display("FAIL early_load got %0d want 0", load_seen - l0); else passed++;
    press(1, 0, 0);
    total++; if (load_seen !== l0 + 1) $display("FAIL commit_load_count got %0d want 1", load_seen - l0); else passed++;
    total++; if ({cap_hr, cap_min, cap_sec} !== {5'd0, 6'd59, 6'd31})
      $display("FAIL commit_value got %0d:%0d:%0d want 0:59:31", cap_hr, cap_min, cap_sec); else passed++;
    total++; if (cap_run_en !== 1'b1) $display("FAIL commit_run_en got %b want 1", cap_run_en); else passed++;
    total++; if (mode !== 2'd0 || run_en !== 1'b1 || load !== 1'b0)
      $display("FAIL after_commit got mode=%0d run_en=%b load=%b want 0/1/0", mode, run_en, load); else passed++;
    total++; if ({load_hr, load_min, load_sec} !== {5'd0, 6'd59, 6'd31})
      $display("FAIL load_hold got %0d:%0d:%0d want 0:59:31", load_hr, load_min, load_sec); else passed++;
  endtask

  task automatic test_clamp();
    cur_hr = 5'd31; cur_min = 6'd63; cur_sec = 6'd60;
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    total++; if ({cap_hr, cap_min, cap_sec} !== {5'd23, 6'd59, 6'd59})
      $display("FAIL clamp got %0d:%0d:%0d want 23:59:59", cap_hr, cap_min, cap_sec); else passed++;
  endtask

  task automatic test_simultaneous();
    cur_hr = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
    press(1, 0, 0); press(1, 0, 0);
    press(0, 1, 1);
    total++; if (mode !== 2'd2) $display("FAIL inc_dec_state got %0d want 2", mode); else passed++;
    press(1, 1, 0);
    total++; if (mode !== 2'd3) $display("FAIL mode_inc_state got %0d want 3", mode); else passed++;
    press(1, 0, 0);
    total++; if ({cap_hr, cap_min, cap_sec} !== {5'd10, 6'd20, 6'd30})
      $display("FAIL simultaneous_value got %0d:%0d:%0d want 10:20:30", cap_hr, cap_min, cap_sec); else passed++;
  endtask

  task automatic test_timeout();
    int l0;
    cur_hr = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
    l0 = load_seen;
    press(1, 0, 0);
    tick(); tick();
    total++; if (mode !== 2'd1) $display("FAIL timeout_two_ticks got %0d want 1", mode); else passed++;
    tick();
    total++; if (mode !== 2'd0 || run_en !== 1'b1 || blink_mask !== 3'b000)
      $display("FAIL timeout_exit got mode=%0d run_en=%b mask=%b want 0/1/000", mode, run_en, blink_mask); else passed++;
    press(1, 0, 0);
    tick(); tick();
    press(0, 1, 0);
    tick();
    total++; if (mode !== 2'd1) $display("FAIL timeout_cleared_t3 got %0d want 1", mode); else passed++;
    tick();
    total++; if (mode !== 2'd1) $display("FAIL timeout_cleared_t4 got %0d want 1", mode); else passed++;
    tick();
    total++; if (mode !== 2'd0) $display("FAIL timeout_cleared_exit got %0d want 0", mode); else passed++;
    total++; if (load_seen !== l0) $display("FAIL timeout_no_load got %0d want 0", load_seen - l0); else passed++;
  endtask

  task automatic test_blink();
    cur_hr = 5'd7; cur_min = 6'd8; cur_sec = 6'd9;
    press(1, 0, 0); press(1, 0, 0);
    total++; if (blink_mask !== 3'b010) $display("FAIL blink_min_entry got %b want 010", blink_mask); else passed++;
    tick();
    total++; if (blink_mask !== 3'b000) $display("FAIL blink_min_tick1 got %b want 000", blink_mask); else passed++;
    tick();
    total++; if (blink_mask !== 3'b010) $display("FAIL blink_min_tick2 got %b want 010", blink_mask); else passed++;
    press(1, 0, 0);
    total++; if (blink_mask !== 3'b001) $display("FAIL blink_sec_entry got %b want 001", blink_mask); else passed++;
    press(1, 0, 0);
    tick();
    total++; if (blink_mask !== 3'b000 || mode !== 2'd0)
      $display("FAIL blink_run got mask=%b mode=%0d want 000/0", blink_mask, mode); else passed++;
  endtask

  task automatic test_reset_mid_edit();
    int l0;
    l0 = load_seen;
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    total++; if (mode !== 2'd3 || {load_hr, load_min, load_sec} !== {5'd7, 6'd8, 6'd9})
      $display("FAIL pre_reset got mode=%0d load=%0d:%0d:%0d want 3 7:8:9", mode, load_hr, load_min, load_sec); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (mode !== 2'd0 || run_en !== 1'b1 || load !== 1'b0)
      $display("FAIL mid_reset_ctrl got mode=%0d run_en=%b load=%b want 0/1/0", mode, run_en, load); else passed++;
    total++; if ({load_hr, load_min, load_sec} !== 17'd0 || blink_mask !== 3'b000)
      $display("FAIL mid_reset_vals got %0d:%0d:%0d mask=%b want 0:0:0/000", load_hr, load_min, load_sec, blink_mask); else passed++;
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(10);
    total++; if (load_seen !== l0 || mode !== 2'd0)
      $display("FAIL mid_reset_no_load got loads=%0d mode=%0d want 0/0", load_seen - l0, mode); else passed++;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_full_set();
    test_clamp();
    test_simultaneous();
    test_timeout();
    test_blink();
    test_reset_mid_edit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Time-setting controller for the digital clock.
- Sits between the raw push-buttons and the hr/min/sec counter.
  - Debounces the buttons.
  - Sequences an edit FSM (RUN → SET_HR → SET_MIN → SET_SEC).
  - Freezes the counter while the user edits.
  - Issues a one-cycle load of the edited time into the counter.
- Drives a blink mask so the seven-segment display can flash the field being edited.
- Runs on the fast board clock; uses the 1 Hz divider output only as a clock-enable tick.

Parameters:
- DEBOUNCE_CYCLES, 1000000: number of clk cycles the synchronized button must stay stable before its debounced level changes (10 ms at 100 MHz).
- IDLE_TIMEOUT, 30: number of tick_1hz pulses with no button event in a SET state before the edit is aborted.

Ports:
- clk  in  1  board clock, single clock domain.
- reset  in  1  asynchronous, active-low reset.
- tick_1hz  in  1  one-clk-wide pulse, once per second, synchronous to clk.
- btn_mode  in  1  raw mode button, active-high, asynchronous.
- btn_inc  in  1  raw increment button, active-high, asynchronous.
- btn_dec  in  1  raw decrement button, active-high, asynchronous.
- cur_hr  in  5  current hour from the counter, 0..23.
- cur_min  in  6  current minute, 0..59.
- cur_sec  in  6  current second, 0..59.
- run_en  out  1  counter count-enable; 0 freezes the counter.
- load  out  1  one-cycle strobe; counter takes load_hr/min/sec.
- load_hr  out  5  hour value to load.
- load_min  out  6  minute value to load.
- load_sec  out  6  second value to load.
- blink_mask  out  3  blink enables: bit2 = hr digits, bit1 = min, bit0 = sec.
- mode  out  2  current state: 0 = RUN, 1 = SET_HR, 2 = SET_MIN, 3 = SET_SEC.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = RUN, run_en = 1, load = 0, load_* = 0.
  - Edit regs = 0, blink phase = 0, blink_mask = 000, idle counter = 0.
  - Debounced levels = 0.
  - Reset during editing discards the edit; no load is issued.
- Button path (per button):
  - 2-FF synchronizer, then a stability counter.
  - The debounced level takes the synchronized value after DEBOUNCE_CYCLES consecutive equal samples; any change restarts the count.
  - A press event is a one-cycle pulse on the 0→1 edge of the debounced level.
  - No auto-repeat: holding a button produces exactly one event.
- FSM:
  - All state, edit-reg and output updates are registered and visible on the cycle after the press-event pulse.
  - RUN + mode event: copy cur_hr/min/sec into edit regs, go to SET_HR, run_en = 0.
  - SET_HR + mode event → SET_MIN; SET_MIN + mode event → SET_SEC.
  - SET_SEC + mode event (commit):
    - Drive load_* = edit regs and load = 1 for exactly one cycle.
    - State becomes RUN and run_en = 1 on the same edge.
    - load_* hold their value until the next commit.
- Editing:
  - In SET_x, an inc event adds 1 to the active field and a dec event subtracts 1; other fields are unchanged.
  - Hour wraps 23→0 on inc and 0→23 on dec.
  - Minute and second wrap 59→0 and 0→59.
  - Edit regs that receive out-of-range cur_* values are clamped to max at capture.
- Simultaneous events:
  - mode together with inc or dec: mode is taken, inc/dec ignored.
  - inc and dec in the same cycle: both ignored.
- Timeout:
  - In SET states, the idle counter increments on tick_1hz and clears on any button event.
  - When it reaches IDLE_TIMEOUT: go to RUN, run_en = 1, no load; the counter resumes from its frozen value.
  - If a tick and a button event fall on the same cycle, the event wins and the counter clears.
- Blink:
  - The phase toggles on each tick_1hz while in a SET state and is forced to 0 in RUN.
  - blink_mask = phase on the active field's bit and 0 on the others.
  - In RUN, blink_mask = 000.
  - On entering a SET state, phase resets to 1 so the field goes dark immediately.
- mode output equals the registered state encoding.

Decomposition:
- Shared package clock_pkg holds:
  - State encoding constants (RUN, SET_HR, SET_MIN, SET_SEC).
  - HR_MAX = 23, MIN_MAX = 59, SEC_MAX = 59.
  - Width constants HR_W = 5, MS_W = 6.
  - The blink_mask bit indices.
- Sub-module btn_debounce (synchronizer + stability counter + rising-edge pulse, parameter DEBOUNCE_CYCLES) is instantiated three times.
- FSM, edit regs, timeout and blink logic stay in clock_set_ctrl.

Test Plan:
- Debounce: DEBOUNCE_CYCLES = 4; toggle btn_inc every 2 cycles for 20 cycles, then hold high 10 cycles → exactly one inc event; edit reg changes once.
- Full set: cur = 10:20:30; press mode, inc ×14 (hr 10→23→0), mode, dec ×21 (min 20→59), mode, inc ×1 (sec 31), mode.
  - Expect load = 1 for one cycle with load = 0:59:31.
  - Expect run_en = 0 throughout editing and 1 from the commit cycle on.
- Simultaneous: in SET_MIN, inc and dec events in the same cycle → min unchanged; mode and inc in the same cycle → state SET_SEC, min unchanged.
- Timeout: IDLE_TIMEOUT = 3; enter SET_HR, then 3 tick_1hz pulses with no presses → mode = 0, run_en = 1, load never asserted.
  - Repeat with an inc event at tick 2 → still in SET_HR after tick 3.
- Blink: in SET_MIN, the mask alternates 010/000 on successive tick_1hz pulses, starting at 010; in RUN it stays 000.
- Reset mid-edit: assert reset low asynchronously (between clk edges) while in SET_SEC → mode = 0, run_en = 1, load = 0, load_* = 0, blink_mask = 000, immediately and with no clk edge.
